// File: rtl/fifo_byte_unloader.sv
// fifo_byte_unloader
// ------------------
// Read-side consumer of a word-wide FIFO. Watches FifoEmpty, issues one read
// opcode per word, captures the registered FIFO output and replays it as
// BYTE_W-wide beats on a valid/ready stream. The FIFO write side is never
// driven, so Opcode only ever carries 00 (idle) or 10 (read).
//
// Build option:
//   UNLOADER_MSB_FIRST_EN  defined   -> beat 0 is the most-significant byte
//                          undefined -> beat 0 is the least-significant byte
//
// Ports:
//   Clk        in   system clock, everything on posedge
//   Reset      in   synchronous active-high reset
//   FifoEmpty  in   FIFO empty flag, only looked at while idle
//   FifoDout   in   FIFO read data, valid the cycle after Opcode=10
//   Opcode     out  FIFO opcode: 10 = read, 00 = idle
//   ByteOut    out  current beat
//   ByteValid  out  ByteOut holds a beat
//   ByteReady  in   downstream takes the beat when ByteValid && ByteReady
//   Busy       out  high whenever the engine is not idle
//   WordCount  out  number of fully transmitted words, wraps silently
module fifo_byte_unloader #(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              FifoEmpty,
  input  logic [DATA_W-1:0] FifoDout,
  output logic [1:0]        Opcode,
  output logic [BYTE_W-1:0] ByteOut,
  output logic              ByteValid,
  input  logic              ByteReady,
  output logic              Busy,
  output logic [CNT_W-1:0]  WordCount
);

  localparam int BYTES = DATA_W / BYTE_W;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_READ = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    LOAD = 2'd2,
    SEND = 2'd3
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   shift_reg;
  logic [IDX_W-1:0]    idx;

  // Beat selection; the only place the byte order differs between builds.
  function automatic logic [BYTE_W-1:0] beat_sel(input logic [DATA_W-1:0] word,
                                                 input logic [IDX_W-1:0]  i);
    int pos;
`ifdef UNLOADER_MSB_FIRST_EN
    pos = BYTES - 1 - int'(i);
`else
    pos = int'(i);
`endif
    return word[pos*BYTE_W +: BYTE_W];
  endfunction

  // Busy is a pure decode of the state register, so it carries no path from
  // any input.
  assign Busy = (state != IDLE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      Opcode    <= OP_IDLE;
      ByteOut   <= '0;
      ByteValid <= 1'b0;
      WordCount <= '0;
      shift_reg <= '0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          // FifoEmpty is trusted only here: by the time the engine returns to
          // IDLE the flag has settled after the previous read.
          if (!FifoEmpty) begin
            Opcode <= OP_READ;
            state  <= READ;
          end
        end
        READ: begin
          // The read opcode is held for exactly this one cycle.
          Opcode <= OP_IDLE;
          state  <= LOAD;
        end
        LOAD: begin
          // FifoDout is registered by the FIFO, so it is valid now.
          shift_reg <= FifoDout;
          idx       <= '0;
          ByteOut   <= beat_sel(FifoDout, '0);
          ByteValid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          // Without ByteReady nothing changes, keeping the beat stable.
          if (ByteReady) begin
            if (idx == LAST_IDX) begin
              WordCount <= WordCount + CNT_W'(1);
              ByteValid <= 1'b0;
              state     <= IDLE;
            end else begin
              idx     <= idx + IDX_W'(1);
              ByteOut <= beat_sel(shift_reg, idx + IDX_W'(1));
            end
          end
        end
        default: begin
          state     <= IDLE;
          Opcode    <= OP_IDLE;
          ByteValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_byte_unloader.sv
// Testbench for fifo_byte_unloader: a FIFO read-side model feeds words, a
// byte scoreboard holds the expected beat stream, and directed sequences
// cover reset, latency, back-to-back words, stalls, mid-word reset and
// WordCount wrap (CNT_W reduced to 8 so the wrap is reachable quickly).
module tb_fifo_byte_unloader;

  localparam int DATA_W = 32;
  localparam int BYTE_W = 8;
  localparam int CNT_W  = 8;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              FifoEmpty;
  logic [DATA_W-1:0] FifoDout;
  logic [1:0]        Opcode;
  logic [BYTE_W-1:0] ByteOut;
  logic              ByteValid;
  logic              ByteReady;
  logic              Busy;
  logic [CNT_W-1:0]  WordCount;

  always #5 Clk = ~Clk;

  fifo_byte_unloader #(
    .DATA_W(DATA_W),
    .BYTE_W(BYTE_W),
    .CNT_W (CNT_W)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .FifoEmpty(FifoEmpty),
    .FifoDout (FifoDout),
    .Opcode   (Opcode),
    .ByteOut  (ByteOut),
    .ByteValid(ByteValid),
    .ByteReady(ByteReady),
    .Busy     (Busy),
    .WordCount(WordCount)
  );

  // FIFO contents and scoreboard
  logic [31:0] mem [0:1023];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic [7:0]  exp_q [$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_reads = 0;
  int underflows = 0;
  int last_rd_cyc = 0;
  int prev_rd_cyc = 0;

  logic [7:0] t2_exp [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [7:0] tb_beat(input logic [31:0] w, input int i);
`ifdef UNLOADER_MSB_FIRST_EN
    return w[8*(3-i) +: 8];
`else
    return w[8*i +: 8];
`endif
  endfunction

  task automatic push_word(input logic [31:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
    FifoEmpty = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(tb_beat(w, i));
  endtask

  // One clock: capture what the DUT presented before the edge, then advance
  // the FIFO model and scoreboard, sampling 1 time unit after the edge.
  task automatic tick();
    logic [1:0] op_b;
    logic       vld_b, rdy_b, rst_b;
    logic [7:0] out_b;
    op_b  = Opcode;
    vld_b = ByteValid;
    rdy_b = ByteReady;
    rst_b = Reset;
    out_b = ByteOut;
    @(posedge Clk);
    #1;
    cyc++;
    if (op_b == 2'b10) begin
      if (rd_ptr == wr_ptr) underflows++;
      else begin
        FifoDout = mem[rd_ptr];
        rd_ptr++;
      end
    end
    FifoEmpty = (rd_ptr == wr_ptr);
    if (vld_b === 1'b1 && rdy_b && !rst_b) begin
      if (exp_q.size() == 0) check("extra_beat", 32'(out_b), 32'hFFFF_FFFF);
      else check("beat", 32'(out_b), 32'(exp_q.pop_front()));
    end
    if (Opcode == 2'b10) begin
      n_reads++;
      prev_rd_cyc = last_rd_cyc;
      last_rd_cyc = cyc;
    end
    if (!rst_b) begin
      check("op_legal", 32'(Opcode == 2'b01 || Opcode == 2'b11), 32'd0);
      check("vld_needs_busy", 32'(ByteValid && !Busy), 32'd0);
    end
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    int n = 0;
    while (!(Busy == 1'b0 && FifoEmpty && exp_q.size() == 0) && n < budget) begin
      if (rnd) ByteReady = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    ByteReady = 1'b1;
    check("idle_timeout", 32'(n < budget), 32'd1);
  endtask

  initial begin
    int reads0;
    int wc0;
`ifdef UNLOADER_MSB_FIRST_EN
    t2_exp[0] = 8'hA1; t2_exp[1] = 8'hB2; t2_exp[2] = 8'hC3; t2_exp[3] = 8'hD4;
`else
    t2_exp[0] = 8'hD4; t2_exp[1] = 8'hC3; t2_exp[2] = 8'hB2; t2_exp[3] = 8'hA1;
`endif
    Reset     = 1'b1;
    FifoEmpty = 1'b1;
    FifoDout  = '0;
    ByteReady = 1'b1;

    // Reset and idle with an empty FIFO
    tick();
    tick();
    Reset = 1'b0;
    check("rst_opcode", 32'(Opcode), 32'd0);
    check("rst_byteout", 32'(ByteOut), 32'd0);
    check("rst_valid", 32'(ByteValid), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_wordcount", 32'(WordCount), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("empty_opcode", 32'(Opcode), 32'd0);
      check("empty_valid", 32'(ByteValid), 32'd0);
      check("empty_busy", 32'(Busy), 32'd0);
      check("empty_wc", 32'(WordCount), 32'd0);
    end

    // Single word, exact latency and beat order
    reads0 = n_reads;
    push_word(32'hA1B2C3D4);
    tick();
    check("t2_read_pulse", 32'(Opcode), 32'd2);
    check("t2_busy", 32'(Busy), 32'd1);
    tick();
    check("t2_load_op", 32'(Opcode), 32'd0);
    check("t2_load_valid", 32'(ByteValid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_valid", 32'(ByteValid), 32'd1);
      check("t2_byte", 32'(ByteOut), 32'(t2_exp[i]));
      check("t2_op_idle", 32'(Opcode), 32'd0);
    end
    tick();
    check("t2_done_valid", 32'(ByteValid), 32'd0);
    check("t2_wordcount", 32'(WordCount), 32'd1);
    check("t2_one_read", 32'(n_reads - reads0), 32'd1);

    // Two back-to-back words
    reads0 = n_reads;
    wc0 = int'(WordCount);
    push_word(32'h11223344);
    push_word(32'h55667788);
    wait_idle(100, 1'b0);
    check("t4_reads", 32'(n_reads - reads0), 32'd2);
    check("t4_read_spacing", 32'(last_rd_cyc - prev_rd_cyc), 32'd7);
    check("t4_wordcount", 32'(int'(WordCount) - wc0), 32'd2);
    check("t4_underflow", 32'(underflows), 32'd0);

    // Stall on beat 1
    reads0 = n_reads;
    wc0 = int'(WordCount);
    push_word(32'hCAFEF00D);
    tick();
    tick();
    tick();
    tick();
    ByteReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_stall_valid", 32'(ByteValid), 32'd1);
      check("t5_stall_byte", 32'(ByteOut), 32'(tb_beat(32'hCAFEF00D, 1)));
      check("t5_stall_op", 32'(Opcode), 32'd0);
    end
    ByteReady = 1'b1;
    wait_idle(50, 1'b0);
    check("t5_reads", 32'(n_reads - reads0), 32'd1);
    check("t5_wordcount", 32'(int'(WordCount) - wc0), 32'd1);

    // Reset mid-word: remaining beats dropped, word not counted
    wc0 = int'(WordCount);
    push_word(32'hDEADBEEF);
    for (int i = 0; i < 5; i++) tick();
    check("t6_pre_valid", 32'(ByteValid), 32'd1);
    check("t6_pre_byte", 32'(ByteOut), 32'(tb_beat(32'hDEADBEEF, 2)));
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    exp_q.delete();
    check("t6_rst_valid", 32'(ByteValid), 32'd0);
    check("t6_rst_busy", 32'(Busy), 32'd0);
    check("t6_rst_wc", 32'(WordCount), 32'd0);
    tick();
    check("t6_idle_after", 32'(Busy), 32'd0);
    wc0 = int'(WordCount);

    // Random words under random back-pressure
    for (int i = 0; i < 6; i++) push_word($urandom);
    wait_idle(400, 1'b1);
    check("rand_wordcount", 32'(int'(WordCount) - wc0), 32'd6);

    // WordCount wrap
    wc0 = int'(WordCount);
    for (int i = 0; i < 255 - wc0; i++) push_word($urandom);
    wait_idle(5000, 1'b0);
    check("wrap_pre", 32'(WordCount), 32'd255);
    push_word(32'h0BADF00D);
    wait_idle(50, 1'b0);
    check("wrap_zero", 32'(WordCount), 32'd0);
    check("final_underflow", 32'(underflows), 32'd0);
    check("final_scoreboard", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
